pc_fetch_unit: RTL and testbench

//   Program-counter / next-PC stage directly upstream of the instruction ROM: holds the

---
 rtl/pc_fetch_unit.sv | 137 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program-counter / next-PC stage ahead of the instruction ROM.
// Selects the next fetch address, stops on leaving the ROM window or a misaligned jr target, and counts retirements.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ROM_WORDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic [15:0] imm16,
    input  logic [25:0] jtarget,
    input  logic [31:0] rs_val,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        redirect,
    output logic        halted,
    output logic        fault,
    output logic [31:0] retired_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    // One past the last legal byte address; 33 bits so the bound itself cannot wrap
    localparam logic [32:0] ROM_LIMIT = 33'(ROM_WORDS) * 33'd4;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] pc_r;
    logic [31:0] pc_nxt_s;
    logic        redirect_r;
    logic        redirect_nxt_s;
    logic [31:0] cnt_r;
    logic [31:0] cnt_nxt_s;

    logic [31:0] seq_s;
    logic [31:0] btgt_s;
    logic [31:0] jtgt_s;
    logic [31:0] sel_s;
    logic        sel_nonseq_s;
    logic        sel_jr_s;

    assign seq_s  = pc_r + 32'd4;
    assign btgt_s = seq_s + {{14{imm16[15]}}, imm16, 2'b00};
    assign jtgt_s = {seq_s[31:28], jtarget, 2'b00};

    // Candidate selection: jr beats j beats taken beq beats sequential
    always_comb begin
        sel_s        = seq_s;
        sel_nonseq_s = 1'b0;
        sel_jr_s     = 1'b0;
        if (jump_reg) begin
            sel_s        = rs_val;
            sel_nonseq_s = 1'b1;
            sel_jr_s     = 1'b1;
        end else if (jump) begin
            sel_s        = jtgt_s;
            sel_nonseq_s = 1'b1;
        end else if (branch && zero) begin
            sel_s        = btgt_s;
            sel_nonseq_s = 1'b1;
        end else begin
            sel_s        = seq_s;
            sel_nonseq_s = 1'b0;
        end
    end

    // Next-state, next-PC, redirect and retirement counter update
    always_comb begin
        state_nxt_s    = state_r;
        pc_nxt_s       = pc_r;
        redirect_nxt_s = redirect_r;
        cnt_nxt_s      = cnt_r;
        case (state_r)
            ST_RUN: begin
                if (stall) begin
                    state_nxt_s = ST_RUN;
                end else if (sel_jr_s && (rs_val[1:0] != 2'b00)) begin
                    state_nxt_s    = ST_FAULT;
                    redirect_nxt_s = 1'b0;
                end else if ({1'b0, sel_s} >= ROM_LIMIT) begin
                    // The instruction that tried to leave the window still retires
                    state_nxt_s    = ST_HALT;
                    redirect_nxt_s = 1'b0;
                    cnt_nxt_s      = cnt_r + 32'd1;
                end else begin
                    pc_nxt_s       = sel_s;
                    redirect_nxt_s = sel_nonseq_s;
                    cnt_nxt_s      = cnt_r + 32'd1;
                end
            end
            ST_HALT: begin
                state_nxt_s    = ST_HALT;
                redirect_nxt_s = 1'b0;
            end
            ST_FAULT: begin
                state_nxt_s    = ST_FAULT;
                redirect_nxt_s = 1'b0;
            end
            default: begin
                // Unreachable encoding: park in FAULT so fetch stops visibly
                state_nxt_s    = ST_FAULT;
                redirect_nxt_s = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_RUN;
            pc_r       <= RESET_PC;
            redirect_r <= 1'b0;
            cnt_r      <= 32'd0;
        end else begin
            state_r    <= state_nxt_s;
            pc_r       <= pc_nxt_s;
            redirect_r <= redirect_nxt_s;
            cnt_r      <= cnt_nxt_s;
        end
    end

    assign pc          = pc_r;
    assign pc_plus4    = seq_s;
    assign redirect    = redirect_r;
    assign retired_cnt = cnt_r;
    assign halted      = (state_r == ST_HALT);
    assign fault       = (state_r == ST_FAULT);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: each task drives one scenario and checks
// outputs against hand-computed values one time unit after the rising edge.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch;
    logic        zero;
    logic        jump;
    logic        jump_reg;
    logic [15:0] imm16;
    logic [25:0] jtarget;
    logic [31:0] rs_val;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        redirect;
    logic        halted;
    logic        fault;
    logic [31:0] retired_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    pc_fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .branch(branch), .zero(zero),
        .jump(jump), .jump_reg(jump_reg), .imm16(imm16), .jtarget(jtarget),
        .rs_val(rs_val), .pc(pc), .pc_plus4(pc_plus4), .redirect(redirect),
        .halted(halted), .fault(fault), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        stall = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0; jump_reg = 1'b0;
        imm16 = 16'h0000; jtarget = 26'd0; rs_val = 32'h0000_0000;
    endtask

    task automatic do_reset();
        clear_ctrl();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++; if (pc !== 32'h0) $display("FAIL rst_pc got %h exp %h", pc, 32'h0); else pass_cnt++;
        total_cnt++; if (pc_plus4 !== 32'h4) $display("FAIL rst_pc_plus4 got %h exp %h", pc_plus4, 32'h4); else pass_cnt++;
        total_cnt++; if (retired_cnt !== 32'd0) $display("FAIL rst_cnt got %0d exp 0", retired_cnt); else pass_cnt++;
        total_cnt++; if ({redirect, halted, fault} !== 3'b000) $display("FAIL rst_flags got %b exp 000", {redirect, halted, fault}); else pass_cnt++;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++; if (pc !== exp_pc[i]) $display("FAIL seq_pc%0d got %h exp %h", i, pc, exp_pc[i]); else pass_cnt++;
        end
        total_cnt++; if (retired_cnt !== 32'd3) $display("FAIL seq_cnt got %0d exp 3", retired_cnt); else pass_cnt++;
        total_cnt++; if (redirect !== 1'b0) $display("FAIL seq_redirect got %b exp 0", redirect); else pass_cnt++;
    endtask

    task automatic test_branch();
        // Taken beq from 0xC, offset +1 word
        do_reset(); tick(); tick(); tick();
        branch = 1'b1; zero = 1'b1; imm16 = 16'h0001;
        tick();
        total_cnt++; if (pc !== 32'h14) $display("FAIL br_taken_pc got %h exp %h", pc, 32'h14); else pass_cnt++;
        total_cnt++; if (redirect !== 1'b1) $display("FAIL br_taken_redirect got %b exp 1", redirect); else pass_cnt++;
        // Not-taken beq from 0xC
        do_reset(); tick(); tick(); tick();
        branch = 1'b1; zero = 1'b0; imm16 = 16'h0001;
        tick();
        total_cnt++; if (pc !== 32'h10) $display("FAIL br_nt_pc got %h exp %h", pc, 32'h10); else pass_cnt++;
        total_cnt++; if (redirect !== 1'b0) $display("FAIL br_nt_redirect got %b exp 0", redirect); else pass_cnt++;
        // Taken beq with offset 0 lands on pc+4 but is still a redirect
        zero = 1'b1; imm16 = 16'h0000;
        tick();
        total_cnt++; if (pc !== 32'h14) $display("FAIL br_zero_pc got %h exp %h", pc, 32'h14); else pass_cnt++;
        total_cnt++; if (redirect !== 1'b1) $display("FAIL br_zero_redirect got %b exp 1", redirect); else pass_cnt++;
        // Backward beq, -3 words: 0x18 - 0xC = 0xC
        imm16 = 16'hFFFD;
        tick();
        total_cnt++; if (pc !== 32'hC) $display("FAIL br_back_pc got %h exp %h", pc, 32'hC); else pass_cnt++;
        total_cnt++; if (retired_cnt !== 32'd6) $display("FAIL br_back_cnt got %0d exp 6", retired_cnt); else pass_cnt++;
    endtask

    task automatic test_halt();
        do_reset();
        jump = 1'b1; jtarget = 26'd9;
        tick();
        total_cnt++; if (pc !== 32'h24) $display("FAIL halt_jpc got %h exp %h", pc, 32'h24); else pass_cnt++;
        clear_ctrl();
        branch = 1'b1; zero = 1'b1; imm16 = 16'h0008;
        tick();
        total_cnt++; if (halted !== 1'b1) $display("FAIL halt_flag got %b exp 1", halted); else pass_cnt++;
        total_cnt++; if (pc !== 32'h24) $display("FAIL halt_pc got %h exp %h", pc, 32'h24); else pass_cnt++;
        total_cnt++; if (retired_cnt !== 32'd2) $display("FAIL halt_cnt got %0d exp 2", retired_cnt); else pass_cnt++;
        total_cnt++; if ({redirect, fault} !== 2'b00) $display("FAIL halt_rf got %b exp 00", {redirect, fault}); else pass_cnt++;
        clear_ctrl();
        jump = 1'b1; jtarget = 26'd1;
        tick(); tick();
        total_cnt++; if (pc !== 32'h24) $display("FAIL halt_abs_pc got %h exp %h", pc, 32'h24); else pass_cnt++;
        total_cnt++; if (retired_cnt !== 32'd2) $display("FAIL halt_abs_cnt got %0d exp 2", retired_cnt); else pass_cnt++;
        total_cnt++; if (halted !== 1'b1) $display("FAIL halt_abs_flag got %b exp 1", halted); else pass_cnt++;
        // Backward branch from 0 wraps to 0xFFFFFFFC and halts
        do_reset();
        branch = 1'b1; zero = 1'b1; imm16 = 16'hFFFE;
        tick();
        total_cnt++; if ({halted, pc} !== {1'b1, 32'h0}) $display("FAIL halt_neg got %b/%h exp 1/%h", halted, pc, 32'h0); else pass_cnt++;
        // Last legal PC 0x3C, then sequential fetch to 0x40 halts
        do_reset();
        jump_reg = 1'b1; rs_val = 32'h3C;
        tick();
        total_cnt++; if ({halted, pc} !== {1'b0, 32'h3C}) $display("FAIL edge_last got %b/%h exp 0/%h", halted, pc, 32'h3C); else pass_cnt++;
        clear_ctrl();
        tick();
        total_cnt++; if ({halted, pc} !== {1'b1, 32'h3C}) $display("FAIL edge_over got %b/%h exp 1/%h", halted, pc, 32'h3C); else pass_cnt++;
        total_cnt++; if (retired_cnt !== 32'd2) $display("FAIL edge_cnt got %0d exp 2", retired_cnt); else pass_cnt++;
    endtask

    task automatic test_stall_and_jr();
        do_reset(); tick(); tick();
        stall = 1'b1; jump = 1'b1; jtarget = 26'd3;
        tick(); tick();
        total_cnt++; if (pc !== 32'h8) $display("FAIL stall_pc got %h exp %h", pc, 32'h8); else pass_cnt++;
        total_cnt++; if (retired_cnt !== 32'd2) $display("FAIL stall_cnt got %0d exp 2", retired_cnt); else pass_cnt++;
        stall = 1'b0;
        tick();
        total_cnt++; if (pc !== 32'hC) $display("FAIL unstall_pc got %h exp %h", pc, 32'hC); else pass_cnt++;
        total_cnt++; if (redirect !== 1'b1) $display("FAIL unstall_redirect got %b exp 1", redirect); else pass_cnt++;
        // jr beats j
        jump_reg = 1'b1; rs_val = 32'h20;
        tick();
        total_cnt++; if (pc !== 32'h20) $display("FAIL jr_prio_pc got %h exp %h", pc, 32'h20); else pass_cnt++;
        total_cnt++; if (retired_cnt !== 32'd4) $display("FAIL jr_prio_cnt got %0d exp 4", retired_cnt); else pass_cnt++;
        // Misaligned jr target faults
        jump = 1'b0; rs_val = 32'h22;
        tick();
        total_cnt++; if (fault !== 1'b1) $display("FAIL jr_fault got %b exp 1", fault); else pass_cnt++;
        total_cnt++; if (pc !== 32'h20) $display("FAIL jr_fault_pc got %h exp %h", pc, 32'h20); else pass_cnt++;
        total_cnt++; if (retired_cnt !== 32'd4) $display("FAIL jr_fault_cnt got %0d exp 4", retired_cnt); else pass_cnt++;
        total_cnt++; if ({halted, redirect} !== 2'b00) $display("FAIL jr_fault_hr got %b exp 00", {halted, redirect}); else pass_cnt++;
        // Reset while in FAULT and stalled
        stall = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; clear_ctrl(); stall = 1'b1;
        total_cnt++; if (pc !== 32'h0) $display("FAIL rst_fault_pc got %h exp %h", pc, 32'h0); else pass_cnt++;
        total_cnt++; if ({redirect, halted, fault} !== 3'b000) $display("FAIL rst_fault_flags got %b exp 000", {redirect, halted, fault}); else pass_cnt++;
        total_cnt++; if (retired_cnt !== 32'd0) $display("FAIL rst_fault_cnt got %0d exp 0", retired_cnt); else pass_cnt++;
        stall = 1'b0;
    endtask

    initial begin
        clear_ctrl();
        rst = 1'b1;
        test_reset();
        test_sequential();
        test_branch();
        test_halt();
        test_stall_and_jr();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
